// File: rtl/data_lookahead_fifo.sv
// 3-entry register FIFO exposing the head beat plus a lookahead of entry 1; keep mask folded into lccnt.
// Latency 1 from push to m_out_*, all outputs registered; s_in_ready depends only on the registered count.
module data_lookahead_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_COUNT   = 16,
  parameter int TAG_WIDTH  = 1,
  parameter int _CFG_WIDTH = $clog2(CH_COUNT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CH_COUNT*DATA_WIDTH-1:0] s_in_data,
  input  logic [TAG_WIDTH-1:0]           s_in_tag,
  input  logic [CH_COUNT-1:0]            s_in_keep,
  input  logic                           s_in_last,
  input  logic                           s_in_valid,
  output logic                           s_in_ready,
  output logic [CH_COUNT*DATA_WIDTH-1:0] m_out_data,
  output logic [TAG_WIDTH-1:0]           m_out_tag,
  output logic [_CFG_WIDTH-1:0]          m_out_lccnt,
  output logic                           m_out_last,
  output logic                           m_out_valid,
  input  logic                           m_out_ready,
  output logic                           m_nxt_valid,
  output logic [_CFG_WIDTH-1:0]          m_nxt_lccnt,
  output logic                           m_nxt_last,
  output logic                           err_keep
);

  localparam int DW = CH_COUNT * DATA_WIDTH;

  typedef struct packed {
    logic [DW-1:0]         data;
    logic [TAG_WIDTH-1:0]  tag;
    logic [_CFG_WIDTH-1:0] lccnt;
    logic                  last;
  } entry_t;

  entry_t                ent_q [3];
  entry_t                ent_d [3];
  logic [1:0]            count_q, count_d;
  logic                  err_keep_q, err_keep_d;
  logic                  push, pop;
  logic [1:0]            wr_idx;
  logic [_CFG_WIDTH-1:0] keep_hi;
  logic                  keep_bad;
  entry_t                in_ent;

  // Highest set keep bit; a valid mask is non-zero and of the form 2^n-1.
  always_comb begin
    keep_hi = '0;
    for (int i = 0; i < CH_COUNT; i++) begin
      if (s_in_keep[i]) keep_hi = _CFG_WIDTH'(i);
    end
    keep_bad = (s_in_keep == '0) ||
               ((s_in_keep & (s_in_keep + CH_COUNT'(1))) != '0);
  end

  always_comb begin
    in_ent.data  = s_in_data;
    in_ent.tag   = s_in_tag;
    in_ent.last  = s_in_last;
    in_ent.lccnt = s_in_last ? keep_hi : _CFG_WIDTH'(CH_COUNT - 1);
  end

  always_comb begin
    push   = s_in_valid && (count_q != 2'd3);
    pop    = m_out_ready && (count_q != 2'd0);
    wr_idx = count_q - {1'b0, pop};
    for (int i = 0; i < 3; i++) ent_d[i] = ent_q[i];
    if (pop) begin
      ent_d[0] = ent_q[1];
      ent_d[1] = ent_q[2];
    end
    // Write after the shift so a simultaneous push lands behind the surviving entries.
    if (push) ent_d[wr_idx] = in_ent;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    err_keep_d = err_keep_q | (push & s_in_last & keep_bad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) ent_q[i] <= '0;
      count_q    <= 2'd0;
      err_keep_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) ent_q[i] <= ent_d[i];
      count_q    <= count_d;
      err_keep_q <= err_keep_d;
    end
  end

  assign s_in_ready  = (count_q != 2'd3);
  assign m_out_valid = (count_q != 2'd0);
  assign m_nxt_valid = count_q[1];
  assign m_out_data  = ent_q[0].data;
  assign m_out_tag   = ent_q[0].tag;
  assign m_out_lccnt = ent_q[0].lccnt;
  assign m_out_last  = ent_q[0].last;
  assign m_nxt_lccnt = ent_q[1].lccnt;
  assign m_nxt_last  = ent_q[1].last;
  assign err_keep    = err_keep_q;

endmodule

// File: tb/tb_data_lookahead_fifo.sv
// Bench for data_lookahead_fifo: directed cases then random valid/ready against a queue model.
module tb_data_lookahead_fifo;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] s_in_data = '0;
  logic [0:0]   s_in_tag = '0;
  logic [15:0]  s_in_keep = '0;
  logic         s_in_last = 1'b0;
  logic         s_in_valid = 1'b0;
  logic         s_in_ready;
  logic [255:0] m_out_data;
  logic [0:0]   m_out_tag;
  logic [3:0]   m_out_lccnt;
  logic         m_out_last;
  logic         m_out_valid;
  logic         m_out_ready = 1'b0;
  logic         m_nxt_valid;
  logic [3:0]   m_nxt_lccnt;
  logic         m_nxt_last;
  logic         err_keep;

  data_lookahead_fifo dut (
    .clk(clk), .rst(rst),
    .s_in_data(s_in_data), .s_in_tag(s_in_tag), .s_in_keep(s_in_keep),
    .s_in_last(s_in_last), .s_in_valid(s_in_valid), .s_in_ready(s_in_ready),
    .m_out_data(m_out_data), .m_out_tag(m_out_tag), .m_out_lccnt(m_out_lccnt),
    .m_out_last(m_out_last), .m_out_valid(m_out_valid), .m_out_ready(m_out_ready),
    .m_nxt_valid(m_nxt_valid), .m_nxt_lccnt(m_nxt_lccnt), .m_nxt_last(m_nxt_last),
    .err_keep(err_keep)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic         tag;
    logic [3:0]   lccnt;
    logic         last;
  } beat_t;

  beat_t mq[$];
  bit    err_m = 1'b0;
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Last-channel index = floor(log2(keep)); valid masks are exactly 2^(idx+1)-1.
  function automatic logic [3:0] exp_lc(input logic ls, input logic [15:0] kp);
    if (!ls) return 4'd15;
    if (kp == 16'd0) return 4'd0;
    return 4'($clog2(int'(kp) + 1) - 1);
  endfunction

  function automatic bit exp_bad(input logic ls, input logic [15:0] kp);
    int hi;
    if (!ls) return 1'b0;
    if (kp == 16'd0) return 1'b1;
    hi = $clog2(int'(kp) + 1) - 1;
    return int'(kp) != ((1 << (hi + 1)) - 1);
  endfunction

  task automatic compare_outputs();
    chk("out_vld", m_out_valid, mq.size() >= 1);
    chk("nxt_vld", m_nxt_valid, mq.size() >= 2);
    chk("in_rdy", s_in_ready, mq.size() != 3);
    chk("err_keep", err_keep, err_m);
    if (mq.size() >= 1) begin
      chk("out_data", m_out_data, mq[0].data);
      chk("out_tag", m_out_tag, mq[0].tag);
      chk("out_lccnt", m_out_lccnt, mq[0].lccnt);
      chk("out_last", m_out_last, mq[0].last);
    end
    if (mq.size() >= 2) begin
      chk("nxt_lccnt", m_nxt_lccnt, mq[1].lccnt);
      chk("nxt_last", m_nxt_last, mq[1].last);
    end
  endtask

  // Entered and left at a negedge: drive, check, advance one clock.
  task automatic step(input bit vld, input logic [255:0] d, input logic tg,
                      input logic [15:0] kp, input logic ls, input bit rdy, output bit acc);
    bit    pp;
    beat_t nb;
    s_in_valid  = vld;
    s_in_data   = d;
    s_in_tag    = tg;
    s_in_keep   = kp;
    s_in_last   = ls;
    m_out_ready = rdy;
    compare_outputs();
    acc = vld && (mq.size() != 3);
    pp  = rdy && (mq.size() != 0);
    @(posedge clk);
    if (pp) nb = mq.pop_front();
    if (acc) begin
      nb.data  = d;
      nb.tag   = tg;
      nb.lccnt = exp_lc(ls, kp);
      nb.last  = ls;
      mq.push_back(nb);
      if (exp_bad(ls, kp)) err_m = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    s_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    mq.delete();
    err_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic gen(output logic [255:0] d, output logic tg, output logic [15:0] kp,
                     output logic ls);
    d  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    tg = 1'($urandom_range(0, 1));
    ls = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 7) == 0) kp = 16'($urandom);
    else kp = 16'((32'd1 << $urandom_range(1, 16)) - 32'd1);
  endtask

  task automatic drain();
    bit a;
    for (int k = 0; k < 10 && mq.size() != 0; k++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, a);
    chk("drained", m_out_valid, 1'b0);
  endtask

  initial begin
    logic [255:0] d;
    logic         tg, ls;
    logic [15:0]  kp;
    bit           acc;
    int           pushed, cyc;
    bit           did_rst;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_rdy", s_in_ready, 1'b1);
    chk("rst_out_vld", m_out_valid, 1'b0);
    chk("rst_nxt_vld", m_nxt_valid, 1'b0);
    chk("rst_out_last", m_out_last, 1'b0);
    chk("rst_nxt_last", m_nxt_last, 1'b0);
    chk("rst_out_lccnt", m_out_lccnt, 4'd0);
    chk("rst_nxt_lccnt", m_nxt_lccnt, 4'd0);
    chk("rst_err", err_keep, 1'b0);

    // One non-last beat, downstream stalled.
    gen(d, tg, kp, ls);
    step(1'b1, d, tg, 16'h0, 1'b0, 1'b0, acc);
    chk("t1_vld", m_out_valid, 1'b1);
    chk("t1_lccnt", m_out_lccnt, 4'd15);
    chk("t1_nxt", m_nxt_valid, 1'b0);

    // Fill to three; entry 1 is a last beat with keep 0x00FF.
    gen(d, tg, kp, ls);
    step(1'b1, d, tg, 16'h00FF, 1'b1, 1'b0, acc);
    gen(d, tg, kp, ls);
    step(1'b1, d, tg, 16'h0, 1'b0, 1'b0, acc);
    chk("t2_full_rdy", s_in_ready, 1'b0);
    chk("t2_nxt_vld", m_nxt_valid, 1'b1);
    chk("t2_nxt_lccnt", m_nxt_lccnt, 4'd7);
    chk("t2_nxt_last", m_nxt_last, 1'b1);
    gen(d, tg, kp, ls);
    step(1'b1, d, tg, kp, ls, 1'b0, acc);
    chk("t2_hold", acc, 1'b0);

    // Held beat then streaming push+pop at count 2.
    for (int k = 0; k < 101; k++) begin
      step(1'b1, d, tg, kp, ls, 1'b1, acc);
      if (acc) gen(d, tg, kp, ls);
    end
    chk("t3_cnt2_nxt", m_nxt_valid, 1'b1);
    chk("t3_cnt2_rdy", s_in_ready, 1'b1);
    drain();
    do_reset();

    // Contiguous short last beat.
    gen(d, tg, kp, ls);
    step(1'b1, d, tg, 16'h0, 1'b0, 1'b0, acc);
    gen(d, tg, kp, ls);
    step(1'b1, d, tg, 16'h000F, 1'b1, 1'b0, acc);
    chk("t4_nxt_lccnt", m_nxt_lccnt, 4'd3);
    chk("t4_nxt_last", m_nxt_last, 1'b1);
    step(1'b0, d, tg, kp, ls, 1'b1, acc);
    chk("t4_out_lccnt", m_out_lccnt, 4'd3);
    chk("t4_out_last", m_out_last, 1'b1);
    chk("t4_err", err_keep, 1'b0);
    drain();

    // Bad keep masks: sticky error.
    gen(d, tg, kp, ls);
    step(1'b1, d, tg, 16'h0005, 1'b1, 1'b0, acc);
    chk("t5_err1", err_keep, 1'b1);
    chk("t5_lccnt2", m_out_lccnt, 4'd2);
    gen(d, tg, kp, ls);
    step(1'b1, d, tg, 16'h0000, 1'b1, 1'b0, acc);
    chk("t5_err2", err_keep, 1'b1);
    chk("t5_lccnt0", m_nxt_lccnt, 4'd0);
    drain();
    chk("t5_err_sticky", err_keep, 1'b1);
    do_reset();
    chk("t5_err_clr", err_keep, 1'b0);

    // Random traffic with a mid-stream reset.
    pushed  = 0;
    cyc     = 0;
    did_rst = 1'b0;
    gen(d, tg, kp, ls);
    while (pushed < 10000 && cyc < 60000) begin
      step($urandom_range(0, 3) != 0, d, tg, kp, ls, $urandom_range(0, 3) != 0, acc);
      cyc++;
      if (acc) begin
        pushed++;
        gen(d, tg, kp, ls);
      end
      if (pushed == 5000 && !did_rst) begin
        did_rst = 1'b1;
        do_reset();
        chk("mid_rst_out_vld", m_out_valid, 1'b0);
        chk("mid_rst_nxt_vld", m_nxt_valid, 1'b0);
        chk("mid_rst_rdy", s_in_ready, 1'b1);
      end
    end
    chk("rand_beats", pushed, 10000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
